// File: rtl/fwd_operand_unit_pkg.sv
// ---------------------------------------------------------------------------
// spu_fwd_pkg
// Shared widths, types and small helpers for the RF/FWD operand unit.
//   REG_W   : operand width (128)
//   ADDR_W  : register number width (7)
//   NSTAGE  : forward stages per pipe (index 0 unused, 1 youngest)
//   LAT_W   : width of one scoreboard countdown
// ---------------------------------------------------------------------------
package spu_fwd_pkg;

    localparam int REG_W  = 128;
    localparam int ADDR_W = 7;
    localparam int NSTAGE = 7;
    localparam int LAT_W  = 3;
    localparam int NREG   = 1 << ADDR_W;

    typedef logic [0:REG_W-1]  reg_t;
    typedef logic [0:ADDR_W-1] raddr_t;
    // Bit 0 flags the operand as used, bits 1..ADDR_W hold the register number.
    typedef logic [0:ADDR_W]   src_t;
    typedef logic [LAT_W-1:0]  lat_t;

    // One pipe's forward-stage staging registers.
    typedef struct packed {
        reg_t   [NSTAGE-1:0] value;
        raddr_t [NSTAGE-1:0] addr;
        logic   [NSTAGE-1:0] write;
    } fw_bus_t;

    function automatic lat_t lat_max(lat_t a, lat_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic lat_t lat_dec(lat_t a);
        return (a == '0) ? '0 : a - lat_t'(1);
    endfunction

endpackage

// File: rtl/fwd_operand_unit_if.sv
// ---------------------------------------------------------------------------
// fwd_operand_unit_if
// Bundles the forwarding network, register-file reads, issue information and
// the operand/stall results of the RF/FWD stage.
//   master : the pipes / issue logic (drive staging registers and sources)
//   slave  : fwd_operand_unit (drives operands and RAW stalls)
// ---------------------------------------------------------------------------
interface fwd_operand_unit_if;
    import spu_fwd_pkg::*;

    reg_t   [NSTAGE-1:0] ev_fw_wb;
    reg_t   [NSTAGE-1:0] od_fw_wb;
    raddr_t [NSTAGE-1:0] ev_fw_addr_wb;
    raddr_t [NSTAGE-1:0] od_fw_addr_wb;
    logic   [NSTAGE-1:0] ev_fw_write_wb;
    logic   [NSTAGE-1:0] od_fw_write_wb;

    reg_t   ev_rt_wb, od_rt_wb;
    raddr_t ev_rt_addr_wb, od_rt_addr_wb;
    logic   ev_reg_write_wb, od_reg_write_wb;

    src_t   ra_even_addr, rb_even_addr, rc_even_addr, ra_odd_addr, rb_odd_addr;
    reg_t   ra_even_rf, rb_even_rf, rc_even_rf, ra_odd_rf, rb_odd_rf;

    logic   ev_issue, od_issue;
    raddr_t ev_rt_addr, od_rt_addr;
    logic   ev_reg_write, od_reg_write;
    lat_t   ev_lat, od_lat;
    logic   branch_kill;

    reg_t   ra_even, rb_even, rc_even, ra_odd, rb_odd;
    logic   stall_even_raw, stall_odd_raw;

    modport master (
        output ev_fw_wb, od_fw_wb, ev_fw_addr_wb, od_fw_addr_wb,
               ev_fw_write_wb, od_fw_write_wb,
               ev_rt_wb, od_rt_wb, ev_rt_addr_wb, od_rt_addr_wb,
               ev_reg_write_wb, od_reg_write_wb,
               ra_even_addr, rb_even_addr, rc_even_addr, ra_odd_addr, rb_odd_addr,
               ra_even_rf, rb_even_rf, rc_even_rf, ra_odd_rf, rb_odd_rf,
               ev_issue, od_issue, ev_rt_addr, od_rt_addr,
               ev_reg_write, od_reg_write, ev_lat, od_lat, branch_kill,
        input  ra_even, rb_even, rc_even, ra_odd, rb_odd,
               stall_even_raw, stall_odd_raw
    );

    modport slave (
        input  ev_fw_wb, od_fw_wb, ev_fw_addr_wb, od_fw_addr_wb,
               ev_fw_write_wb, od_fw_write_wb,
               ev_rt_wb, od_rt_wb, ev_rt_addr_wb, od_rt_addr_wb,
               ev_reg_write_wb, od_reg_write_wb,
               ra_even_addr, rb_even_addr, rc_even_addr, ra_odd_addr, rb_odd_addr,
               ra_even_rf, rb_even_rf, rc_even_rf, ra_odd_rf, rb_odd_rf,
               ev_issue, od_issue, ev_rt_addr, od_rt_addr,
               ev_reg_write, od_reg_write, ev_lat, od_lat, branch_kill,
        output ra_even, rb_even, rc_even, ra_odd, rb_odd,
               stall_even_raw, stall_odd_raw
    );

endinterface

// File: rtl/fwd_operand_unit_mux.sv
// ---------------------------------------------------------------------------
// fwd_mux
// Combinational priority select for one source operand.
//   i_src            : source descriptor (bit 0 used, bits 1..7 register)
//   i_rf             : register-file read data
//   i_ev_fw/i_od_fw  : forward-stage registers of the even / odd pipe
//   i_*_rt*          : write-back registers of each pipe
//   o_operand        : selected operand
// Priority: youngest matching forward stage (odd over even at equal stage),
// then write-back (odd over even), then the register file. Stage 0 is never
// a candidate.
// ---------------------------------------------------------------------------
module fwd_mux
    import spu_fwd_pkg::*;
(
    input  src_t    i_src,
    input  reg_t    i_rf,
    input  fw_bus_t i_ev_fw,
    input  fw_bus_t i_od_fw,
    input  reg_t    i_ev_rt,
    input  raddr_t  i_ev_rt_addr,
    input  logic    i_ev_rt_write,
    input  reg_t    i_od_rt,
    input  raddr_t  i_od_rt_addr,
    input  logic    i_od_rt_write,
    output reg_t    o_operand
);

    raddr_t w_reg;
    logic   w_unused_stage0;

    assign w_reg = i_src[1:ADDR_W];
    assign w_unused_stage0 = ^{i_ev_fw.value[0], i_ev_fw.addr[0], i_ev_fw.write[0],
                               i_od_fw.value[0], i_od_fw.addr[0], i_od_fw.write[0]};

    // Candidates are visited from lowest to highest priority so that the last
    // matching assignment is the winner.
    always_comb begin
        o_operand = i_rf;
        if (i_src[0]) begin
            if (i_ev_rt_write && (i_ev_rt_addr == w_reg)) o_operand = i_ev_rt;
            if (i_od_rt_write && (i_od_rt_addr == w_reg)) o_operand = i_od_rt;
            for (int s = NSTAGE - 1; s >= 1; s--) begin
                if (i_ev_fw.write[s] && (i_ev_fw.addr[s] == w_reg)) o_operand = i_ev_fw.value[s];
                if (i_od_fw.write[s] && (i_od_fw.addr[s] == w_reg)) o_operand = i_od_fw.value[s];
            end
        end
    end

endmodule

// File: rtl/fwd_operand_unit.sv
// ---------------------------------------------------------------------------
// fwd_operand_unit
// RF/FWD-stage operand unit: per-register latency scoreboard, RAW stall
// detection and forwarding of five source operands.
//   clk          : rising-edge clock
//   reset        : asynchronous, active-low; clears scoreboard and stats
//   bus (slave)  : forwarding network, sources, issue info, operands, stalls
//   stall_cycles : saturating count of stalled clocks, only when the macro
//                  FWD_STALL_STATS_EN is defined
// ---------------------------------------------------------------------------
module fwd_operand_unit
    import spu_fwd_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    fwd_operand_unit_if.slave  bus
`ifdef FWD_STALL_STATS_EN
    ,
    output logic [31:0]        stall_cycles
`endif
);

    lat_t    r_cnt      [NREG];
    lat_t    w_cnt_next [NREG];
    logic    w_stall_even, w_stall_odd, w_stall;
    logic    w_ev_go, w_od_go;
    fw_bus_t w_ev_fw, w_od_fw;
    src_t    w_src [5];
    reg_t    w_rf  [5];
    reg_t    w_op  [5];

    // The countdown reaches 1 in the cycle whose closing edge delivers the
    // result into forward stage 1, so only counts above 1 still hold a reader.
    function automatic logic src_blocks(src_t src, lat_t cnt);
        return src[0] && (cnt > lat_t'(1));
    endfunction

    assign w_stall_even = src_blocks(bus.ra_even_addr, r_cnt[bus.ra_even_addr[1:ADDR_W]])
                        | src_blocks(bus.rb_even_addr, r_cnt[bus.rb_even_addr[1:ADDR_W]])
                        | src_blocks(bus.rc_even_addr, r_cnt[bus.rc_even_addr[1:ADDR_W]]);
    assign w_stall_odd  = src_blocks(bus.ra_odd_addr, r_cnt[bus.ra_odd_addr[1:ADDR_W]])
                        | src_blocks(bus.rb_odd_addr, r_cnt[bus.rb_odd_addr[1:ADDR_W]]);
    assign w_stall      = w_stall_even | w_stall_odd;

    assign bus.stall_even_raw = w_stall_even;
    assign bus.stall_odd_raw  = w_stall_odd;

    assign w_ev_go = bus.ev_issue & bus.ev_reg_write & ~w_stall;
    assign w_od_go = bus.od_issue & bus.od_reg_write & ~w_stall & ~bus.branch_kill;

    // Next scoreboard: every entry counts down; an issuing destination keeps
    // the larger of its remaining count and the new latency, which also
    // resolves both pipes targeting the same register.
    always_comb begin
        for (int i = 0; i < NREG; i++) w_cnt_next[i] = lat_dec(r_cnt[i]);
        if (w_ev_go) w_cnt_next[bus.ev_rt_addr] = lat_max(w_cnt_next[bus.ev_rt_addr], bus.ev_lat);
        if (w_od_go) w_cnt_next[bus.od_rt_addr] = lat_max(w_cnt_next[bus.od_rt_addr], bus.od_lat);
    end

    // Scoreboard register; reset empties it immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

`ifdef FWD_STALL_STATS_EN
    logic [31:0] r_stall_cycles;

    // Saturating count of clocks spent stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

    assign w_ev_fw.value = bus.ev_fw_wb;
    assign w_ev_fw.addr  = bus.ev_fw_addr_wb;
    assign w_ev_fw.write = bus.ev_fw_write_wb;
    assign w_od_fw.value = bus.od_fw_wb;
    assign w_od_fw.addr  = bus.od_fw_addr_wb;
    assign w_od_fw.write = bus.od_fw_write_wb;

    assign w_src[0] = bus.ra_even_addr;
    assign w_src[1] = bus.rb_even_addr;
    assign w_src[2] = bus.rc_even_addr;
    assign w_src[3] = bus.ra_odd_addr;
    assign w_src[4] = bus.rb_odd_addr;
    assign w_rf[0]  = bus.ra_even_rf;
    assign w_rf[1]  = bus.rb_even_rf;
    assign w_rf[2]  = bus.rc_even_rf;
    assign w_rf[3]  = bus.ra_odd_rf;
    assign w_rf[4]  = bus.rb_odd_rf;

    for (genvar g = 0; g < 5; g++) begin : g_mux
        fwd_mux u_mux (
            .i_src         (w_src[g]),
            .i_rf          (w_rf[g]),
            .i_ev_fw       (w_ev_fw),
            .i_od_fw       (w_od_fw),
            .i_ev_rt       (bus.ev_rt_wb),
            .i_ev_rt_addr  (bus.ev_rt_addr_wb),
            .i_ev_rt_write (bus.ev_reg_write_wb),
            .i_od_rt       (bus.od_rt_wb),
            .i_od_rt_addr  (bus.od_rt_addr_wb),
            .i_od_rt_write (bus.od_reg_write_wb),
            .o_operand     (w_op[g])
        );
    end

    assign bus.ra_even = w_op[0];
    assign bus.rb_even = w_op[1];
    assign bus.rc_even = w_op[2];
    assign bus.ra_odd  = w_op[3];
    assign bus.rb_odd  = w_op[4];

endmodule
